dir_sharer_dispatch: RTL and testbench
======================================

# dir_sharer_dispatch

Downstream stage of the directory coherence state machine for one memory block. It consumes the per-transition command (`escrita`, `sharers`, `dataValueReply`) and the requesting node ID. It maintains the block's sharer bit-vector and serialises the resulting invalidate/fetch messages to remote nodes and the data-value reply to the requester over valid/ready channels. It applies back-pressure to the directory FSM through `cmd_ready` while a command is in flight.

## Interface
- `NODES`, 4: number of processor nodes tracked.
- `ID_W`, 2: node-ID width; must be at least clog2(NODES).

- `clock`  in  1  sole clock, rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  high only in IDLE.
- `escrita`  in  2  00 none, 01 invalidate, 10 fetch, 11 fetch-invalidate.
- `sharers`  in  2  00 no change, 01 clear, 10 set to {p}, 11 add p.
- `data_value_reply`  in  1  send reply to requester after messages.
- `requester`  in  ID_W  node p.
- `msg_valid` / `msg_ready`  out / in  1 / 1  remote-message handshake.
- `msg_type`  out  2  copy of the latched `escrita` code.
- `msg_dest`  out  ID_W  target node.
- `fetch_done`  in  1  one-cycle pulse: owner writeback complete.
- `reply_valid` / `reply_ready`  out / in  1 / 1  reply handshake.
- `reply_dest`  out  ID_W  latched requester.
- `sharer_vec`  out  NODES  current sharer set, registered.
- `proto_err`  out  1  sticky protocol error (see Configuration).

## Operation
- States: IDLE, SEND, WAIT_FETCH, REPLY.
- Accept: `cmd_valid && cmd_ready`. Latch `escrita`, `data_value_reply` and `requester`.
- In the accept cycle:
  - pending mask = old `sharer_vec` & ~onehot(requester) when `escrita` != 00, else 0.
  - The sharer update is applied in the same cycle (set: vec = onehot(p); add: vec |= onehot(p); clear: vec = 0).
  - onehot of a requester >= NODES is 0.
- Next state after accept:
  - SEND if the mask is non-zero.
  - Else WAIT_FETCH if `escrita[1]` is set and the mask is non-empty. This is unreachable, so fetch with an empty mask skips WAIT_FETCH.
  - Else REPLY if `data_value_reply` is set.
  - Else IDLE.
- An all-zero command is accepted and has no effect.
- SEND:
  - `msg_dest` = lowest set bit of the mask.
  - On handshake, clear that bit.
  - When the mask empties: WAIT_FETCH if `escrita[1]`, else REPLY if reply is requested, else IDLE.
- WAIT_FETCH: on `fetch_done`, go to REPLY if reply is requested, else IDLE. `fetch_done` is ignored in every other state.
- REPLY: `reply_valid` is held until `reply_ready`, then IDLE.
- Reset mid-operation discards pending messages and clears `sharer_vec`.

## Timing
- All outputs are registered except `cmd_ready`, which is decoded from the state register.
- Reset values:
  - `sharer_vec` = 0, `msg_valid` = 0, `reply_valid` = 0, `proto_err` = 0.
  - `msg_type` = 00, `msg_dest` = 0, `reply_dest` = 0.
  - State = IDLE.
- Accept at cycle T: `sharer_vec` is updated and the first `msg_valid` is asserted at T+1.
- With `msg_ready` held high, each message takes one cycle.
- `reply_valid` asserts the cycle after the last message handshake, or the cycle after `fetch_done`.
- `cmd_ready` returns the cycle after the final handshake.
- `msg_valid`, `msg_type` and `msg_dest` stay stable until accepted. The same holds for the reply signals.

## Configuration
- `DIR_PROTO_CHECK_EN` defined:
  - `proto_err` sets, and stays set until reset, on any of these:
    - fetch or fetch-invalidate with an empty mask;
    - fetch with more than one target;
    - `requester` >= NODES;
    - `cmd_valid` while not in IDLE.
  - Datapath behaviour is unchanged.
- Undefined: `proto_err` is tied to 0 and no checking logic is generated.

## Structure
- Package `dir_pkg` holds:
  - `escrita` code constants (`ESC_NONE`, `ESC_INV`, `ESC_FETCH`, `ESC_FETCH_INV`);
  - sharer-op constants (`SHR_NOP`, `SHR_CLR`, `SHR_SET`, `SHR_ADD`);
  - the state enum.
- One sub-module `dir_lowest_one`: combinational lowest-set-bit finder returning an index and a found flag, parameterised by NODES.

## Test plan
- Reset, then read miss from node 2 (`sharers` = 10, reply = 1) -> no message; reply to 2 at T+1; `sharer_vec` = 0100.
- Vec = 0111, invalidate + set from node 3, ready high -> messages (01, dest 0) at T+1, (01, 1) at T+2, (01, 2) at T+3; reply to 3 at T+4; vec = 1000.
- Vec = 0010, fetch-invalidate from node 0 -> message (11, dest 1), waits for `fetch_done` pulsed 5 cycles later; reply the next cycle; vec = 0001.
- `msg_ready` low for 3 cycles on the second invalidate -> `msg_dest` and `msg_type` stable, no message skipped; `cmd_ready` stays low.
- `reset_n` low during SEND -> all valids 0 and vec = 0 next cycle; a new command is accepted afterwards.
- With `DIR_PROTO_CHECK_EN`: fetch with vec = 0 -> `proto_err` = 1 and stays 1; reply still issued at T+1.

Source files
------------

// File: rtl/dir_pkg.sv
// ----------------------------------------------------------------------------
// dir_pkg
// Shared definitions for the directory sharer/dispatch stage:
//   - escrita message codes (ESC_*), which also appear unchanged on msg_type
//   - sharer-vector update opcodes (SHR_*)
//   - dispatch FSM state encoding (dir_state_t)
// ----------------------------------------------------------------------------
package dir_pkg;

   localparam logic [1:0] ESC_NONE      = 2'b00;
   localparam logic [1:0] ESC_INV       = 2'b01;
   localparam logic [1:0] ESC_FETCH     = 2'b10;
   localparam logic [1:0] ESC_FETCH_INV = 2'b11;

   localparam logic [1:0] SHR_NOP = 2'b00;
   localparam logic [1:0] SHR_CLR = 2'b01;
   localparam logic [1:0] SHR_SET = 2'b10;
   localparam logic [1:0] SHR_ADD = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE       = 2'd0,
      ST_SEND       = 2'd1,
      ST_WAIT_FETCH = 2'd2,
      ST_REPLY      = 2'd3
   } dir_state_t;

endpackage

// File: rtl/dir_lowest_one.sv
// ----------------------------------------------------------------------------
// dir_lowest_one
// Combinational lowest-set-bit finder.
// Ports:
//   vec    in   NODES  bit-vector to search
//   idx    out  ID_W   index of the lowest set bit (0 when none)
//   found  out  1      high when vec has at least one bit set
// ----------------------------------------------------------------------------
module dir_lowest_one #(
   parameter int NODES = 4,
   parameter int ID_W  = 2
) (
   input  logic [NODES-1:0] vec,
   output logic [ID_W-1:0]  idx,
   output logic             found
);

   // Scan from the top down so the last hit, i.e. the lowest index, wins.
   always_comb begin
      idx   = '0;
      found = 1'b0;
      for (int i = NODES - 1; i >= 0; i--) begin
         if (vec[i]) begin
            idx   = ID_W'(i);
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/dir_sharer_dispatch.sv
// ----------------------------------------------------------------------------
// dir_sharer_dispatch
// Downstream stage of the directory coherence FSM for one memory block.
// Keeps the block's sharer bit-vector, serialises invalidate/fetch messages
// to remote sharers, optionally waits for the owner writeback, then sends the
// data-value reply to the requester. cmd_ready is high only in IDLE.
//
// Ports:
//   clock, reset_n                 clock / synchronous active-low reset
//   cmd_valid, cmd_ready           command handshake
//   escrita, sharers               message code / sharer-vector opcode
//   data_value_reply, requester    reply request / requesting node
//   msg_valid, msg_ready           remote-message handshake
//   msg_type, msg_dest             latched escrita code / target node
//   fetch_done                     owner writeback complete pulse
//   reply_valid, reply_ready       reply handshake
//   reply_dest                     latched requester
//   sharer_vec                     registered sharer set
//   proto_err                      sticky protocol error
//
// Build option: define DIR_PROTO_CHECK_EN to generate the protocol checker;
// otherwise proto_err is tied low.
//
// state          | meaning
// ---------------+-----------------------------------------------------------
// ST_IDLE        | ready for a command
// ST_SEND        | issuing one message per set bit of the pending mask
// ST_WAIT_FETCH  | all messages sent, waiting for the owner writeback
// ST_REPLY       | holding reply_valid until the requester takes it
// ----------------------------------------------------------------------------
module dir_sharer_dispatch
   import dir_pkg::*;
#(
   parameter int NODES = 4,
   parameter int ID_W  = 2
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       escrita,
   input  logic [1:0]       sharers,
   input  logic             data_value_reply,
   input  logic [ID_W-1:0]  requester,
   output logic             msg_valid,
   input  logic             msg_ready,
   output logic [1:0]       msg_type,
   output logic [ID_W-1:0]  msg_dest,
   input  logic             fetch_done,
   output logic             reply_valid,
   input  logic             reply_ready,
   output logic [ID_W-1:0]  reply_dest,
   output logic [NODES-1:0] sharer_vec,
   output logic             proto_err
);

   dir_state_t       state_q, state_d;
   logic [NODES-1:0] mask_q, mask_d, mask_acc;
   logic [NODES-1:0] vec_q, vec_d;
   logic [NODES-1:0] req_oh, dest_oh;
   logic [1:0]       esc_q, esc_d;
   logic             rep_q, rep_d;
   logic [ID_W-1:0]  req_q, req_d;
   logic [ID_W-1:0]  dest_q, dest_d;
   logic [ID_W-1:0]  low_idx;
   logic             low_found;
   logic             mv_q, rv_q;
   logic             accept;

   assign cmd_ready = (state_q == ST_IDLE);
   assign accept    = cmd_valid && cmd_ready;

   // Out-of-range node IDs decode to an all-zero one-hot.
   always_comb begin
      req_oh  = '0;
      dest_oh = '0;
      for (int i = 0; i < NODES; i++) begin
         req_oh[i]  = (32'(requester) == 32'(i));
         dest_oh[i] = (32'(dest_q) == 32'(i));
      end
   end

   // The requester never messages itself, so it is masked out of the targets.
   assign mask_acc = (escrita != ESC_NONE) ? (vec_q & ~req_oh) : '0;

   always_comb begin
      state_d = state_q;
      mask_d  = mask_q;
      vec_d   = vec_q;
      esc_d   = esc_q;
      rep_d   = rep_q;
      req_d   = req_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               esc_d  = escrita;
               rep_d  = data_value_reply;
               req_d  = requester;
               mask_d = mask_acc;
               case (sharers)
                  SHR_CLR: vec_d = '0;
                  SHR_SET: vec_d = req_oh;
                  SHR_ADD: vec_d = vec_q | req_oh;
                  default: vec_d = vec_q;
               endcase
               // A fetch with no target has no owner to wait for, so it
               // falls straight through to the reply decision.
               if (mask_acc != '0)
                  state_d = ST_SEND;
               else if (data_value_reply)
                  state_d = ST_REPLY;
               else
                  state_d = ST_IDLE;
            end
         end
         ST_SEND: begin
            // msg_valid is always high in this state.
            if (msg_ready) begin
               mask_d = mask_q & ~dest_oh;
               if (mask_d == '0) begin
                  if (esc_q[1])
                     state_d = ST_WAIT_FETCH;
                  else if (rep_q)
                     state_d = ST_REPLY;
                  else
                     state_d = ST_IDLE;
               end
            end
         end
         ST_WAIT_FETCH: begin
            if (fetch_done)
               state_d = rep_q ? ST_REPLY : ST_IDLE;
         end
         ST_REPLY: begin
            if (reply_ready)
               state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   dir_lowest_one #(
      .NODES (NODES),
      .ID_W  (ID_W)
   ) u_lowest (
      .vec   (mask_d),
      .idx   (low_idx),
      .found (low_found)
   );

   // Destination only moves when another target remains, which keeps it
   // stable while a message is stalled.
   assign dest_d = low_found ? low_idx : dest_q;

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         mask_q  <= '0;
         vec_q   <= '0;
         esc_q   <= ESC_NONE;
         rep_q   <= 1'b0;
         req_q   <= '0;
         dest_q  <= '0;
         mv_q    <= 1'b0;
         rv_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         mask_q  <= mask_d;
         vec_q   <= vec_d;
         esc_q   <= esc_d;
         rep_q   <= rep_d;
         req_q   <= req_d;
         dest_q  <= dest_d;
         mv_q    <= (state_d == ST_SEND);
         rv_q    <= (state_d == ST_REPLY);
      end
   end

   assign msg_valid   = mv_q;
   assign msg_type    = esc_q;
   assign msg_dest    = dest_q;
   assign reply_valid = rv_q;
   assign reply_dest  = req_q;
   assign sharer_vec  = vec_q;

`ifdef DIR_PROTO_CHECK_EN
   logic proto_hit, proto_q;

   always_comb begin
      proto_hit = 1'b0;
      if (accept) begin
         if (escrita[1] && (mask_acc == '0))
            proto_hit = 1'b1;
         // More than one bit set: clearing the lowest leaves something behind.
         if ((escrita == ESC_FETCH) && ((mask_acc & (mask_acc - NODES'(1))) != '0))
            proto_hit = 1'b1;
         if (32'(requester) >= 32'(NODES))
            proto_hit = 1'b1;
      end
      if (cmd_valid && !cmd_ready)
         proto_hit = 1'b1;
   end

   always_ff @(posedge clock) begin
      if (!reset_n)
         proto_q <= 1'b0;
      else if (proto_hit)
         proto_q <= 1'b1;
   end

   assign proto_err = proto_q;
`else
   assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_dir_sharer_dispatch.sv
// ----------------------------------------------------------------------------
// tb_dir_sharer_dispatch
// Scoreboard bench for dir_sharer_dispatch: a small reference model of the
// sharer vector predicts each message and reply (with its cycle when the
// ready inputs are held high); a monitor pops and compares on handshakes.
// ----------------------------------------------------------------------------
module tb_dir_sharer_dispatch;

   localparam int NODES = 4;
   localparam int ID_W  = 2;

   logic             clock = 1'b0;
   logic             reset_n = 1'b0;
   logic             cmd_valid = 1'b0;
   logic             cmd_ready;
   logic [1:0]       escrita = 2'b00;
   logic [1:0]       sharers = 2'b00;
   logic             data_value_reply = 1'b0;
   logic [ID_W-1:0]  requester = '0;
   logic             msg_valid;
   logic             msg_ready = 1'b1;
   logic [1:0]       msg_type;
   logic [ID_W-1:0]  msg_dest;
   logic             fetch_done = 1'b0;
   logic             reply_valid;
   logic             reply_ready = 1'b1;
   logic [ID_W-1:0]  reply_dest;
   logic [NODES-1:0] sharer_vec;
   logic             proto_err;

   dir_sharer_dispatch #(.NODES(NODES), .ID_W(ID_W)) dut (
      .clock            (clock),
      .reset_n          (reset_n),
      .cmd_valid        (cmd_valid),
      .cmd_ready        (cmd_ready),
      .escrita          (escrita),
      .sharers          (sharers),
      .data_value_reply (data_value_reply),
      .requester        (requester),
      .msg_valid        (msg_valid),
      .msg_ready        (msg_ready),
      .msg_type         (msg_type),
      .msg_dest         (msg_dest),
      .fetch_done       (fetch_done),
      .reply_valid      (reply_valid),
      .reply_ready      (reply_ready),
      .reply_dest       (reply_dest),
      .sharer_vec       (sharer_vec),
      .proto_err        (proto_err)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   typedef struct {
      logic [1:0]      typ;
      logic [ID_W-1:0] dest;
      int              at;
   } msg_t;

   typedef struct {
      logic [ID_W-1:0] dest;
      int              at;
   } rep_t;

   msg_t exp_msg[$];
   rep_t exp_rep[$];
   msg_t mon_m;
   rep_t mon_r;

   int n_tests = 0;
   int n_fail  = 0;
   logic [NODES-1:0] model_vec = '0;

`ifdef DIR_PROTO_CHECK_EN
   localparam logic PROTO_EXP = 1'b1;
`else
   localparam logic PROTO_EXP = 1'b0;
`endif

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Handshakes complete on the following rising edge with the values seen here.
   always @(negedge clock) begin
      if (reset_n && msg_valid && msg_ready) begin
         if (exp_msg.size() == 0) begin
            check("msg_unexpected", 32'(msg_dest), 32'hFFFF);
         end else begin
            mon_m = exp_msg.pop_front();
            check("msg_type", 32'(msg_type), 32'(mon_m.typ));
            check("msg_dest", 32'(msg_dest), 32'(mon_m.dest));
            if (mon_m.at >= 0) check("msg_cycle", 32'(cyc), 32'(mon_m.at));
         end
      end
      if (reset_n && reply_valid && reply_ready) begin
         if (exp_rep.size() == 0) begin
            check("reply_unexpected", 32'(reply_dest), 32'hFFFF);
         end else begin
            mon_r = exp_rep.pop_front();
            check("reply_dest", 32'(reply_dest), 32'(mon_r.dest));
            if (mon_r.at >= 0) check("reply_cycle", 32'(cyc), 32'(mon_r.at));
         end
      end
   end

   task automatic wait_idle();
      int k = 0;
      @(negedge clock);
      while (!cmd_ready && k < 100) begin
         @(negedge clock);
         k++;
      end
      check("idle_timeout", 32'(cmd_ready), 32'd1);
   endtask

   // Drives one command, updates the model and queues the expected traffic.
   task automatic issue(input logic [1:0] esc, input logic [1:0] shr, input logic rep,
                        input logic [ID_W-1:0] req, input bit timed);
      logic [NODES-1:0] oh, mask;
      int t, n;
      wait_idle();
      t = cyc;
      escrita = esc;
      sharers = shr;
      data_value_reply = rep;
      requester = req;
      cmd_valid = 1'b1;
      @(posedge clock);
      #1;
      cmd_valid = 1'b0;
      oh = '0;
      oh[req] = 1'b1;
      mask = (esc != 2'b00) ? (model_vec & ~oh) : '0;
      case (shr)
         2'b01:   model_vec = '0;
         2'b10:   model_vec = oh;
         2'b11:   model_vec = model_vec | oh;
         default: model_vec = model_vec;
      endcase
      n = 0;
      for (int i = 0; i < NODES; i++) begin
         if (mask[i]) begin
            exp_msg.push_back('{esc, ID_W'(i), timed ? t + 1 + n : -1});
            n++;
         end
      end
      if (rep)
         exp_rep.push_back('{req, (timed && !(esc[1] && mask != '0)) ? t + 1 + n : -1});
      @(negedge clock);
      check("sharer_vec", 32'(sharer_vec), 32'(model_vec));
      check("cmd_ready_after", 32'(cmd_ready), 32'((mask == '0) && !rep));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset values
      repeat (3) @(posedge clock);
      @(negedge clock);
      check("rst_msg_valid", 32'(msg_valid), 32'd0);
      check("rst_reply_valid", 32'(reply_valid), 32'd0);
      check("rst_sharer_vec", 32'(sharer_vec), 32'd0);
      check("rst_proto_err", 32'(proto_err), 32'd0);
      check("rst_msg_type", 32'(msg_type), 32'd0);
      check("rst_msg_dest", 32'(msg_dest), 32'd0);
      check("rst_reply_dest", 32'(reply_dest), 32'd0);
      check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      @(posedge clock);
      #1 reset_n = 1'b1;

      // Read miss from node 2: reply only
      issue(2'b00, 2'b10, 1'b1, 2'd2, 1'b1);

      // Build vec = 0111, then invalidate + set from node 3
      issue(2'b00, 2'b11, 1'b0, 2'd0, 1'b1);
      issue(2'b00, 2'b11, 1'b0, 2'd1, 1'b1);
      issue(2'b01, 2'b10, 1'b1, 2'd3, 1'b1);

      // fetch_done in IDLE is ignored
      wait_idle();
      @(posedge clock);
      #1 fetch_done = 1'b1;
      @(posedge clock);
      #1 fetch_done = 1'b0;
      @(negedge clock);
      check("idle_fetch_ignored", 32'(cmd_ready), 32'd1);
      check("idle_no_reply", 32'(reply_valid), 32'd0);

      // vec = 0010, fetch-invalidate + set from node 0
      issue(2'b00, 2'b10, 1'b0, 2'd1, 1'b1);
      issue(2'b11, 2'b10, 1'b1, 2'd0, 1'b1);
      @(posedge clock);
      #1;
      repeat (4) begin
         @(negedge clock);
         check("wf_msg_valid", 32'(msg_valid), 32'd0);
         check("wf_reply_valid", 32'(reply_valid), 32'd0);
         check("wf_cmd_ready", 32'(cmd_ready), 32'd0);
      end
      @(posedge clock);
      #1 fetch_done = 1'b1;
      @(posedge clock);
      #1 fetch_done = 1'b0;
      @(negedge clock);
      check("wf_reply_after_fetch", 32'(reply_valid), 32'd1);

      // Stall on the second invalidate
      issue(2'b00, 2'b11, 1'b0, 2'd1, 1'b1);
      issue(2'b00, 2'b11, 1'b0, 2'd2, 1'b1);
      issue(2'b01, 2'b00, 1'b0, 2'd3, 1'b0);
      @(posedge clock);
      #1 msg_ready = 1'b0;
      repeat (3) begin
         @(negedge clock);
         check("stall_msg_valid", 32'(msg_valid), 32'd1);
         check("stall_msg_dest", 32'(msg_dest), 32'd1);
         check("stall_msg_type", 32'(msg_type), 32'd1);
         check("stall_cmd_ready", 32'(cmd_ready), 32'd0);
      end
      @(posedge clock);
      #1 msg_ready = 1'b1;
      wait_idle();

      // Reset in the middle of SEND
      issue(2'b01, 2'b00, 1'b0, 2'd3, 1'b0);
      @(posedge clock);
      #1 reset_n = 1'b0;
      @(negedge clock);
      @(negedge clock);
      check("midrst_msg_valid", 32'(msg_valid), 32'd0);
      check("midrst_reply_valid", 32'(reply_valid), 32'd0);
      check("midrst_sharer_vec", 32'(sharer_vec), 32'd0);
      check("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
      exp_msg.delete();
      exp_rep.delete();
      model_vec = '0;
      @(posedge clock);
      #1 reset_n = 1'b1;
      issue(2'b00, 2'b10, 1'b1, 2'd1, 1'b1);
      check("proto_err_clean", 32'(proto_err), 32'd0);

      // Clear, then fetch with an empty mask; finally an all-zero command
      issue(2'b00, 2'b01, 1'b0, 2'd0, 1'b1);
      issue(2'b10, 2'b00, 1'b1, 2'd0, 1'b1);
      check("proto_err_fetch_empty", 32'(proto_err), 32'(PROTO_EXP));
      issue(2'b00, 2'b00, 1'b0, 2'd2, 1'b1);
      check("proto_err_sticky", 32'(proto_err), 32'(PROTO_EXP));

      wait_idle();
      repeat (2) @(negedge clock);
      check("msg_queue_drained", 32'(exp_msg.size()), 32'd0);
      check("reply_queue_drained", 32'(exp_rep.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
